// File: rtl/key_digit_scanner_if.sv
// key_digit_scanner_if: load/scalar/step bundle between the point-multiplication
// controller (master) and the digit scanner (slave).
interface key_digit_scanner_if #(
    parameter int KEY_W   = 32,
    parameter int DIGIT_W = 1
);
    localparam int NDIG = KEY_W / DIGIT_W;
    localparam int IDXW = $clog2(NDIG) + 1;

    logic               load;
    logic [KEY_W-1:0]   key_in;
    logic               skip_lz;
    logic               step_req;
    logic [DIGIT_W-1:0] digit_out;
    logic [IDXW-1:0]    digit_idx;
    logic               digit_valid;
    logic               last;
    logic               step_ack;
    logic               busy;
    logic               done;

    modport master (
        output load, key_in, skip_lz, step_req,
        input  digit_out, digit_idx, digit_valid, last,
        input  step_ack, busy, done
    );

    modport slave (
        input  load, key_in, skip_lz, step_req,
        output digit_out, digit_idx, digit_valid, last,
        output step_ack, busy, done
    );
endinterface

// File: rtl/key_digit_scanner.sv
// key_digit_scanner: latches a scalar and hands it to the controller one
// DIGIT_W-bit digit at a time, with optional leading-zero skip.
module key_digit_scanner #(
    parameter int KEY_W     = 32,
    parameter int DIGIT_W   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    key_digit_scanner_if.slave bus
);
    localparam int NDIG = KEY_W / DIGIT_W;
    localparam int IDXW = $clog2(NDIG) + 1;

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SKIP  = 3'd1;
    localparam logic [2:0] READY = 3'd2;
    localparam logic [2:0] ACK   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             skip_q, skip_d;

    logic [DIGIT_W-1:0] dig_cur;
    logic [DIGIT_W-1:0] dig_nxt;
    logic               idx_at_last;
    logic [IDXW-1:0]    idx_inc;

    // Extract the digit at scan position i in the configured scan order.
    function automatic logic [DIGIT_W-1:0] pick(
        input logic [KEY_W-1:0] k,
        input logic [IDXW-1:0]  i
    );
        logic [31:0]      pos;
        logic [KEY_W-1:0] s;
        pos = 32'(i) * 32'(DIGIT_W);
        if (MSB_FIRST != 0) begin
            pos = 32'(KEY_W - DIGIT_W) - pos;
        end
        s = k >> pos;
        return s[DIGIT_W-1:0];
    endfunction

    assign idx_at_last = (idx_q == IDX_LAST);
    assign idx_inc     = idx_at_last ? idx_q : idx_q + IDX_ONE;
    assign dig_cur     = pick(key_q, idx_q);
    assign dig_nxt     = pick(key_q, idx_inc);

    // Next-state logic; load overrides whatever the current state wants.
    // SKIP looks one digit ahead so k skipped digits cost exactly k cycles.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        skip_d  = skip_q;
        if (bus.load) begin
            key_d   = bus.key_in;
            skip_d  = bus.skip_lz;
            idx_d   = '0;
            state_d = (bus.skip_lz && MSB_FIRST != 0) ? SKIP : READY;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                SKIP: begin
                    if (skip_q && dig_cur == '0 && !idx_at_last) begin
                        idx_d = idx_inc;
                        if (dig_nxt != '0 || idx_inc == IDX_LAST) begin
                            state_d = READY;
                        end
                    end else begin
                        state_d = READY;
                    end
                end
                READY: begin
                    if (bus.step_req) begin
                        state_d = ACK;
                    end
                end
                ACK: begin
                    if (idx_at_last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = READY;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset abandons any scan in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            skip_q  <= skip_d;
        end
    end

    assign bus.digit_out   = dig_cur;
    assign bus.digit_idx   = idx_q;
    assign bus.digit_valid = (state_q == READY);
    assign bus.last        = (state_q == READY) && idx_at_last;
    assign bus.step_ack    = (state_q == ACK);
    assign bus.busy        = (state_q == SKIP) || (state_q == READY)
                          || (state_q == ACK);
    assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_key_digit_scanner.sv
// tb_key_digit_scanner: directed vectors on two scanner configurations,
// a 1-bit LSB-first scanner (ia) and a 4-bit MSB-first scanner (ib).
module tb_key_digit_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    key_digit_scanner_if #(.KEY_W(32), .DIGIT_W(1)) ia ();
    key_digit_scanner_if #(.KEY_W(32), .DIGIT_W(4)) ib ();

    key_digit_scanner #(
        .KEY_W(32), .DIGIT_W(1), .MSB_FIRST(0)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(ia.slave)
    );

    key_digit_scanner #(
        .KEY_W(32), .DIGIT_W(4), .MSB_FIRST(1)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(ib.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_idle_outputs(input string tag);
        chk({tag, " dout"},  64'(ib.digit_out), 64'd0);
        chk({tag, " idx"},   64'(ib.digit_idx), 64'd0);
        chk({tag, " valid"}, 64'(ib.digit_valid), 64'd0);
        chk({tag, " last"},  64'(ib.last), 64'd0);
        chk({tag, " ack"},   64'(ib.step_ack), 64'd0);
        chk({tag, " busy"},  64'(ib.busy), 64'd0);
        chk({tag, " done"},  64'(ib.done), 64'd0);
    endtask

    logic [31:0] key1;
    logic [3:0]  exp2 [6];

    initial begin
        ia.load = 0; ia.key_in = '0; ia.skip_lz = 0; ia.step_req = 0;
        ib.load = 0; ib.key_in = '0; ib.skip_lz = 0; ib.step_req = 0;
        tick();
        tick();
        b_idle_outputs("reset");
        chk("reset a done", 64'(ia.done), 64'd0);
        rst = 1'b0;
        tick();

        // 1: LSB-first binary scan of 0x5, step_req held high
        key1 = 32'h0000_0005;
        ia.key_in = key1; ia.load = 1;
        tick();
        ia.load = 0; ia.step_req = 1;
        for (int i = 0; i < 32; i++) begin
            chk("t1 valid", 64'(ia.digit_valid), 64'd1);
            chk("t1 idx",   64'(ia.digit_idx), 64'(i));
            chk("t1 dig",   64'(ia.digit_out), 64'(key1[i]));
            chk("t1 last",  64'(ia.last), 64'(i == 31));
            chk("t1 noack", 64'(ia.step_ack), 64'd0);
            tick();
            chk("t1 ack",   64'(ia.step_ack), 64'd1);
            chk("t1 ackv",  64'(ia.digit_valid), 64'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("t1 done",  64'(ia.done), 64'd1);
            chk("t1 busy",  64'(ia.busy), 64'd0);
            chk("t1 dack",  64'(ia.step_ack), 64'd0);
            tick();
        end
        ia.step_req = 0;

        // 2: MSB-first nibble scan with leading-zero skip
        exp2[0] = 4'hA; exp2[1] = 4'h3; exp2[2] = 4'h0;
        exp2[3] = 4'h0; exp2[4] = 4'h0; exp2[5] = 4'h0;
        ib.key_in = 32'h00A3_0000; ib.skip_lz = 1; ib.load = 1;
        tick();
        ib.load = 0; ib.skip_lz = 0;
        for (int c = 0; c < 2; c++) begin
            chk("t2 skbusy", 64'(ib.busy), 64'd1);
            chk("t2 skval",  64'(ib.digit_valid), 64'd0);
            chk("t2 skidx",  64'(ib.digit_idx), 64'(c));
            tick();
        end
        ib.step_req = 1;
        for (int i = 0; i < 6; i++) begin
            chk("t2 valid", 64'(ib.digit_valid), 64'd1);
            chk("t2 idx",   64'(ib.digit_idx), 64'(i + 2));
            chk("t2 dig",   64'(ib.digit_out), 64'(exp2[i]));
            chk("t2 last",  64'(ib.last), 64'(i == 5));
            tick();
            chk("t2 ack",   64'(ib.step_ack), 64'd1);
            tick();
        end
        chk("t2 done", 64'(ib.done), 64'd1);
        ib.step_req = 0;

        // 3: all-zero key with skip stops on the final digit
        ib.key_in = 32'h0; ib.skip_lz = 1; ib.load = 1;
        tick();
        ib.load = 0; ib.skip_lz = 0;
        chk("t3 clrdone", 64'(ib.done), 64'd0);
        for (int c = 0; c < 7; c++) begin
            chk("t3 skval", 64'(ib.digit_valid), 64'd0);
            chk("t3 skidx", 64'(ib.digit_idx), 64'(c));
            tick();
        end
        chk("t3 valid", 64'(ib.digit_valid), 64'd1);
        chk("t3 idx",   64'(ib.digit_idx), 64'd7);
        chk("t3 dig",   64'(ib.digit_out), 64'd0);
        chk("t3 last",  64'(ib.last), 64'd1);
        ib.step_req = 1;
        tick();
        chk("t3 ack", 64'(ib.step_ack), 64'd1);
        tick();
        chk("t3 done", 64'(ib.done), 64'd1);
        ib.step_req = 0;

        // 4: stall in READY for 10 cycles
        ib.key_in = 32'h1234_5678; ib.load = 1;
        tick();
        ib.load = 0;
        for (int c = 0; c < 10; c++) begin
            chk("t4 valid", 64'(ib.digit_valid), 64'd1);
            chk("t4 dig",   64'(ib.digit_out), 64'd1);
            chk("t4 idx",   64'(ib.digit_idx), 64'd0);
            chk("t4 noack", 64'(ib.step_ack), 64'd0);
            tick();
        end

        // 5: async reset at idx 5
        ib.step_req = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
        end
        chk("t5 idx", 64'(ib.digit_idx), 64'd5);
        chk("t5 dig", 64'(ib.digit_out), 64'd6);
        ib.step_req = 0;
        #2;
        rst = 1'b1;
        #1;
        b_idle_outputs("t5 async");
        chk("t5 a done", 64'(ia.done), 64'd0);
        #1;
        rst = 1'b0;
        tick();
        b_idle_outputs("t5 post");
        ib.key_in = 32'hFFFF_FFFF; ib.load = 1;
        tick();
        ib.load = 0;
        chk("t5 valid", 64'(ib.digit_valid), 64'd1);
        chk("t5 nidx",  64'(ib.digit_idx), 64'd0);
        chk("t5 ndig",  64'(ib.digit_out), 64'hF);

        // 6: reload while READY at idx 3
        ib.step_req = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
        end
        chk("t6 idx3", 64'(ib.digit_idx), 64'd3);
        chk("t6 rdy",  64'(ib.digit_valid), 64'd1);
        ib.key_in = 32'h9000_0000; ib.load = 1;
        tick();
        ib.load = 0; ib.step_req = 0;
        chk("t6 idx",   64'(ib.digit_idx), 64'd0);
        chk("t6 dig",   64'(ib.digit_out), 64'h9);
        chk("t6 valid", 64'(ib.digit_valid), 64'd1);
        chk("t6 ack",   64'(ib.step_ack), 64'd0);
        chk("t6 done",  64'(ib.done), 64'd0);
        tick();
        chk("t6 hold",  64'(ib.digit_idx), 64'd0);
        chk("t6 ack2",  64'(ib.step_ack), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
